// File: rtl/result_buffer.sv
// ---------------------------------------------------------------------------
// result_buffer
// Collects converted numbers into a small register-file buffer, then on
// request plays them back over a valid/ready stream.
//
// Ports
//   clk                   : clock, all state changes on the rising edge
//   rst                   : asynchronous active-high reset
//   storeConvertedNumber  : write strobe, stores convertedNumber at index cnt
//   convertedNumber       : value to store (WIDTH bits)
//   enC                   : increments the entry counter cnt (saturating)
//   writeToFile           : starts draining the first min(cnt, DEPTH) entries
//   cnt                   : entry counter, fed back to the sequencing controller
//   out_data / out_valid  : drained entry and its valid flag
//   out_ready             : sink accepts out_data
//   busy                  : high while draining
//   done                  : one-cycle pulse after a drain completes
//   overflow              : sticky, a store was attempted with cnt >= DEPTH
// ---------------------------------------------------------------------------
module result_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             storeConvertedNumber,
  input  logic [WIDTH-1:0] convertedNumber,
  input  logic             enC,
  input  logic             writeToFile,
  output logic [31:0]      cnt,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [31:0]   DEPTH_W = 32'(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]    rd_ptr;
  logic [LW-1:0]    len;
  logic [LW-1:0]    next_ptr;
  logic [LW-1:0]    latch_len;
  logic             cnt_in_range;
  logic             store_ok;

  assign cnt_in_range = (cnt < DEPTH_W);
  assign latch_len    = cnt_in_range ? cnt[LW-1:0] : DEPTH_L;
  assign next_ptr     = rd_ptr + ONE_L;

  // writeToFile wins over a store in the same cycle, and stores are only
  // accepted in IDLE while there is still room.
  assign store_ok = (state == IDLE) && storeConvertedNumber && !writeToFile &&
                    cnt_in_range && !rst;

  // The buffer itself has no reset so its contents survive a reset.
  always_ff @(posedge clk) begin
    if (store_ok) begin
      mem[cnt[AW-1:0]] <= convertedNumber;
    end
  end

  // Control FSM. out_data is preloaded one beat ahead so the stream can
  // move one entry per clock, and all status outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_ptr    <= '0;
      len       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (writeToFile) begin
            rd_ptr <= '0;
            len    <= latch_len;
            if (latch_len != '0) begin
              state     <= DRAIN;
              out_valid <= 1'b1;
              busy      <= 1'b1;
              out_data  <= mem[0];
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            if (storeConvertedNumber && !cnt_in_range) begin
              overflow <= 1'b1;
            end
            if (enC && (cnt != 32'hFFFF_FFFF)) begin
              cnt <= cnt + 32'd1;
            end
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            if (next_ptr == len) begin
              state     <= DONE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              rd_ptr   <= next_ptr;
              out_data <= mem[next_ptr[AW-1:0]];
            end
          end
        end
        DONE: begin
          done     <= 1'b0;
          cnt      <= '0;
          overflow <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_buffer.sv
// Self-checking bench for result_buffer: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences.
module tb_result_buffer;

  logic        clk;
  logic        rst;
  logic        storeConvertedNumber;
  logic [15:0] convertedNumber;
  logic        enC;
  logic        writeToFile;
  logic [31:0] cnt;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        overflow;

  int totalChecks;
  int passedChecks;

  result_buffer #(.WIDTH(16), .DEPTH(25)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .storeConvertedNumber (storeConvertedNumber),
    .convertedNumber      (convertedNumber),
    .enC                  (enC),
    .writeToFile          (writeToFile),
    .cnt                  (cnt),
    .out_data             (out_data),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .busy                 (busy),
    .done                 (done),
    .overflow             (overflow)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        store;
    logic [15:0] conv;
    logic        enc;
    logic        wtf;
    logic        ready;
    logic [31:0] eCnt;
    logic        eValid;
    logic        chkData;
    logic [15:0] eData;
    logic        eBusy;
    logic        eDone;
    logic        eOvf;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mkVec(input logic r, input logic s, input int cv,
                                 input logic e, input logic w, input logic rd,
                                 input int ec, input logic ev, input logic cd,
                                 input int ed, input logic eb, input logic edn,
                                 input logic eo);
    vec_t v;
    v.rst = r; v.store = s; v.conv = 16'(cv); v.enc = e; v.wtf = w;
    v.ready = rd; v.eCnt = 32'(ec); v.eValid = ev; v.chkData = cd;
    v.eData = 16'(ed); v.eBusy = eb; v.eDone = edn; v.eOvf = eo;
    return v;
  endfunction

  // Compare one observed value against the bench's expectation
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    totalChecks++;
    if (act === exp) begin
      passedChecks++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one table vector's inputs
  task automatic applyStimulus(input vec_t v);
    rst                  = v.rst;
    storeConvertedNumber = v.store;
    convertedNumber      = v.conv;
    enC                  = v.enc;
    writeToFile          = v.wtf;
    out_ready            = v.ready;
  endtask

  task automatic idleInputs();
    storeConvertedNumber = 1'b0;
    convertedNumber      = '0;
    enC                  = 1'b0;
    writeToFile          = 1'b0;
    out_ready            = 1'b0;
  endtask

  // Synchronous-looking reset pulse, entered and left on a negedge
  task automatic pulseReset();
    idleInputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One store+enC pair
  task automatic storeIncr(input int value);
    storeConvertedNumber = 1'b1;
    convertedNumber      = 16'(value);
    enC                  = 1'b1;
    @(negedge clk);
    storeConvertedNumber = 1'b0;
    enC                  = 1'b0;
  endtask

  // Start a drain with the sink always ready and expect n beats base..base+n-1
  task automatic drainExpect(input string tag, input int base, input int n);
    int beats;
    beats       = 0;
    writeToFile = 1'b1;
    out_ready   = 1'b1;
    @(negedge clk);
    writeToFile = 1'b0;
    for (int c = 0; c < n + 5; c++) begin
      if (!out_valid) break;
      checkOutput($sformatf("%s_data%0d", tag, beats), 32'(out_data), 32'(base + beats));
      beats++;
      @(negedge clk);
    end
    checkOutput($sformatf("%s_beats", tag), 32'(beats), 32'(n));
    checkOutput($sformatf("%s_done", tag), 32'(done), 32'd1);
    checkOutput($sformatf("%s_busy_at_done", tag), 32'(busy), 32'd0);
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("%s_done_clear", tag), 32'(done), 32'd0);
    checkOutput($sformatf("%s_cnt_clear", tag), cnt, 32'd0);
    checkOutput($sformatf("%s_ovf_clear", tag), 32'(overflow), 32'd0);
  endtask

  initial begin
    int ptr;
    int cyc;
    logic sawDone;
    logic sawActive;
    logic readyPat [6];

    totalChecks  = 0;
    passedChecks = 0;
    rst = 1'b1;
    idleInputs();

    //               rst st conv en wtf rdy  cnt v cd data b d o
    vecs[0]  = mkVec(1, 0, 0,  0, 0, 0,   0, 0, 0, 0,  0, 0, 0);
    vecs[1]  = mkVec(0, 0, 0,  0, 0, 0,   0, 0, 0, 0,  0, 0, 0);
    vecs[2]  = mkVec(0, 1, 7,  1, 0, 0,   1, 0, 0, 0,  0, 0, 0);
    vecs[3]  = mkVec(0, 1, 9,  1, 0, 0,   2, 0, 0, 0,  0, 0, 0);
    vecs[4]  = mkVec(0, 1, 11, 0, 0, 0,   2, 0, 0, 0,  0, 0, 0);
    vecs[5]  = mkVec(0, 0, 0,  1, 0, 0,   3, 0, 0, 0,  0, 0, 0);
    vecs[6]  = mkVec(0, 1, 5,  1, 1, 0,   3, 1, 1, 7,  1, 0, 0);
    vecs[7]  = mkVec(0, 1, 5,  1, 0, 0,   3, 1, 1, 7,  1, 0, 0);
    vecs[8]  = mkVec(0, 0, 0,  0, 0, 1,   3, 1, 1, 9,  1, 0, 0);
    vecs[9]  = mkVec(0, 0, 0,  0, 0, 1,   3, 1, 1, 11, 1, 0, 0);
    vecs[10] = mkVec(0, 0, 0,  0, 0, 1,   3, 0, 0, 0,  0, 1, 0);
    vecs[11] = mkVec(0, 0, 0,  0, 0, 0,   0, 0, 0, 0,  0, 0, 0);
    vecs[12] = mkVec(0, 0, 0,  0, 1, 0,   0, 0, 0, 0,  0, 1, 0);
    vecs[13] = mkVec(0, 0, 0,  0, 0, 0,   0, 0, 0, 0,  0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_cnt", i), cnt, vecs[i].eCnt);
      checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].eValid));
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].eBusy));
      checkOutput($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].eDone));
      checkOutput($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].eOvf));
      if (vecs[i].chkData) begin
        checkOutput($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].eData));
      end
    end
    idleInputs();

    // Full frame of 25 entries drained at full rate
    pulseReset();
    for (int i = 0; i < 25; i++) storeIncr(100 + i);
    checkOutput("frame_cnt", cnt, 32'd25);
    checkOutput("frame_ovf", 32'(overflow), 32'd0);
    drainExpect("frame", 100, 25);

    // Backpressure: ready pattern 1,0,0,1,0,1 over a 3-entry drain
    pulseReset();
    for (int i = 0; i < 3; i++) storeIncr(50 + i);
    readyPat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    writeToFile = 1'b1;
    out_ready   = 1'b0;
    @(negedge clk);
    writeToFile = 1'b0;
    ptr = 0;
    cyc = 0;
    while (ptr < 3 && cyc < 6) begin
      checkOutput($sformatf("bp_valid_c%0d", cyc), 32'(out_valid), 32'd1);
      checkOutput($sformatf("bp_data_c%0d", cyc), 32'(out_data), 32'(50 + ptr));
      out_ready = readyPat[cyc];
      if (readyPat[cyc]) ptr++;
      cyc++;
      @(negedge clk);
    end
    checkOutput("bp_accepted", 32'(ptr), 32'd3);
    checkOutput("bp_done", 32'(done), 32'd1);
    checkOutput("bp_valid_end", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Overflow: 27 store+enC pairs, only the first 25 land in the buffer
    pulseReset();
    for (int i = 0; i < 27; i++) storeIncr(200 + i);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_cnt", cnt, 32'd27);
    drainExpect("ovf", 200, 25);

    // Abort: reset mid-drain after 10 accepted beats
    pulseReset();
    for (int i = 0; i < 26; i++) storeIncr(300 + i);
    checkOutput("abort_pre_ovf", 32'(overflow), 32'd1);
    writeToFile = 1'b1;
    out_ready   = 1'b1;
    @(negedge clk);
    writeToFile = 1'b0;
    for (int b = 0; b < 10; b++) @(negedge clk);
    checkOutput("abort_beat10_data", 32'(out_data), 32'd310);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_done", 32'(done), 32'd0);
    checkOutput("async_rst_cnt", cnt, 32'd0);
    checkOutput("async_rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b0;
    sawDone   = 1'b0;
    sawActive = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      sawDone   = sawDone | done;
      sawActive = sawActive | busy | out_valid;
    end
    checkOutput("abort_no_done", 32'(sawDone), 32'd0);
    checkOutput("abort_idle", 32'(sawActive), 32'd0);

    // Buffer contents survive reset: count 3 entries without storing, drain
    for (int i = 0; i < 3; i++) begin
      enC = 1'b1;
      @(negedge clk);
    end
    enC = 1'b0;
    checkOutput("keep_cnt", cnt, 32'd3);
    drainExpect("keep", 300, 3);

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
